// File: rtl/alu_pkg.sv
// Shared decode constants for the ALU sequencer: opcodes, FSM encoding, instruction fields.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int NREG   = 8;
  localparam int BR_W   = 8;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDI = 4'b0001;
  localparam logic [3:0] OP_BRZ = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b1010;
  localparam logic [3:0] OP_SUB = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RA_LSB  = 6;
  localparam int RB_LSB  = 3;
  localparam int IMM_W   = 9;

endpackage

// File: rtl/seq_regfile.sv
// 8x32 register file, two async read ports, one sync write port; R0 reads zero, writes to it are dropped.
module seq_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [2:0]        wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [2:0]        ra0,
  output logic [DATA_W-1:0] rd0,
  input  logic [2:0]        ra1,
  output logic [DATA_W-1:0] rd1
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && wa != 3'd0) begin
      mem[wa] <= wd;
    end
  end

  assign rd0 = (ra0 == 3'd0) ? '0 : mem[ra0];
  assign rd1 = (ra1 == 3'd0) ? '0 : mem[ra1];

endmodule

// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer: accepts a 16-bit instruction, drives the external
// combinational ALU during EXEC, commits into the register file, and reports in WB.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [15:0]       in_instr,
  output logic              in_ready,
  output logic [DATA_W-1:0] A_bus,
  output logic [DATA_W-1:0] B_bus,
  output logic [3:0]        op,
  input  logic [DATA_W-1:0] C_bus,
  input  logic              Z,
  output logic              res_valid,
  output logic [2:0]        res_rd,
  output logic [DATA_W-1:0] res_data,
  output logic              br_taken,
  output logic [BR_W-1:0]   br_target,
  output logic              illegal
);

  state_t            state, state_nxt;
  logic [15:0]       instr;
  logic              zflag;
  logic              wr_q, taken_q, ill_q;
  logic [DATA_W-1:0] rdata_a, rdata_b, wdata, imm_sext;
  logic              rf_we;

  logic [3:0] opc;
  logic [2:0] rd, ra, rb;
  logic       is_alu, is_ldi, is_brz, is_nop, is_ill;

  assign opc = instr[OPC_LSB +: 4];
  assign rd  = instr[RD_LSB +: 3];
  assign ra  = instr[RA_LSB +: 3];
  assign rb  = instr[RB_LSB +: 3];
  assign imm_sext = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};

  assign is_alu = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_MUL);
  assign is_ldi = (opc == OP_LDI);
  assign is_brz = (opc == OP_BRZ);
  assign is_nop = (opc == OP_NOP);
  assign is_ill = !(is_alu || is_ldi || is_brz || is_nop);

  // The register write lands at the edge that ends EXEC, so the next accepted
  // instruction already reads the new value.
  assign rf_we = (state == ST_EXEC) && (is_alu || is_ldi);
  assign wdata = is_alu ? C_bus : imm_sext;

  seq_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rf_we),
    .wa    (rd),
    .wd    (wdata),
    .ra0   (ra),
    .rd0   (rdata_a),
    .ra1   (rb),
    .rd1   (rdata_b)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    A_bus     = '0;
    B_bus     = '0;
    op        = OP_NOP;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_alu) begin
          A_bus = rdata_a;
          B_bus = rdata_b;
          op    = opc;
        end
        state_nxt = ST_WB;
      end
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      instr     <= '0;
      zflag     <= 1'b0;
      wr_q      <= 1'b0;
      taken_q   <= 1'b0;
      ill_q     <= 1'b0;
      res_rd    <= '0;
      res_data  <= '0;
      br_target <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && in_valid) instr <= in_instr;
      if (state == ST_EXEC) begin
        wr_q    <= rf_we;
        taken_q <= is_brz && zflag;
        ill_q   <= is_ill;
        if (is_alu) zflag <= Z;
        if (rf_we) begin
          res_rd   <= rd;
          res_data <= wdata;
        end
        if (is_brz) br_target <= instr[BR_W-1:0];
      end
    end
  end

  assign res_valid = (state == ST_WB) && wr_q;
  assign br_taken  = (state == ST_WB) && taken_q;
  assign illegal   = (state == ST_WB) && ill_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU model closing the C_bus/Z loop.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = 16'h0;
  logic        in_ready;
  logic [31:0] A_bus, B_bus, C_bus;
  logic [3:0]  op;
  logic        Z;
  logic        res_valid, br_taken, illegal;
  logic [2:0]  res_rd;
  logic [31:0] res_data;
  logic [7:0]  br_target;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .A_bus(A_bus), .B_bus(B_bus), .op(op),
    .C_bus(C_bus), .Z(Z), .res_valid(res_valid), .res_rd(res_rd),
    .res_data(res_data), .br_taken(br_taken), .br_target(br_target),
    .illegal(illegal)
  );

  always_comb begin
    case (op)
      4'b1010: C_bus = A_bus + B_bus;
      4'b1011: C_bus = A_bus - B_bus;
      4'b1100: C_bus = A_bus * B_bus;
      default: C_bus = 32'h0;
    endcase
    Z = (C_bus == 32'h0);
  end

  typedef struct {
    logic [15:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        rv;
    logic [2:0]  rd;
    logic [31:0] data;
    logic        br;
    logic [7:0]  tgt;
    logic        ill;
  } vec_t;

  function automatic logic [15:0] f_alu(input logic [3:0] o, input logic [2:0] d,
                                        input logic [2:0] a, input logic [2:0] b);
    return {o, d, a, b, 3'b000};
  endfunction

  function automatic logic [15:0] f_ldi(input logic [2:0] d, input logic [8:0] imm);
    return {4'b0001, d, imm};
  endfunction

  function automatic logic [15:0] f_brz(input logic [7:0] t);
    return {4'b0010, 4'b0000, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called one step after a rising edge with the DUT in IDLE; returns likewise.
  task automatic apply(input vec_t v, input int idx);
    chk($sformatf("v%0d ready_idle", idx), {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_instr = v.instr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_instr = 16'hFFFF;
    chk($sformatf("v%0d ready_exec", idx), {31'b0, in_ready}, 32'd0);
    chk($sformatf("v%0d A_bus", idx), A_bus, v.a);
    chk($sformatf("v%0d B_bus", idx), B_bus, v.b);
    chk($sformatf("v%0d op", idx), {28'b0, op}, {28'b0, v.op});
    @(posedge clk); #1;
    chk($sformatf("v%0d ready_wb", idx), {31'b0, in_ready}, 32'd0);
    chk($sformatf("v%0d res_valid", idx), {31'b0, res_valid}, {31'b0, v.rv});
    if (v.rv) begin
      chk($sformatf("v%0d res_rd", idx), {29'b0, res_rd}, {29'b0, v.rd});
      chk($sformatf("v%0d res_data", idx), res_data, v.data);
    end
    chk($sformatf("v%0d br_taken", idx), {31'b0, br_taken}, {31'b0, v.br});
    if (v.br) chk($sformatf("v%0d br_target", idx), {24'b0, br_target}, {24'b0, v.tgt});
    chk($sformatf("v%0d illegal", idx), {31'b0, illegal}, {31'b0, v.ill});
    @(posedge clk); #1;
    chk($sformatf("v%0d pulses_end", idx), {29'b0, res_valid, br_taken, illegal}, 32'd0);
  endtask

  vec_t tbl[21];
  vec_t v;
  logic [15:0] b2b_instr[6];
  int acc_cyc[6];
  int k, nres;

  initial begin
    tbl[0]  = '{f_ldi(3'd1, 9'd5),          32'h0, 32'h0, 4'h0, 1'b1, 3'd1, 32'd5,        1'b0, 8'h00, 1'b0};
    tbl[1]  = '{f_ldi(3'd2, 9'h1FD),        32'h0, 32'h0, 4'h0, 1'b1, 3'd2, 32'hFFFFFFFD, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{f_alu(4'hA, 3'd3, 3'd1, 3'd2), 32'd5, 32'hFFFFFFFD, 4'hA, 1'b1, 3'd3, 32'd2, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{f_ldi(3'd1, 9'd7),          32'h0, 32'h0, 4'h0, 1'b1, 3'd1, 32'd7,        1'b0, 8'h00, 1'b0};
    tbl[4]  = '{f_ldi(3'd2, 9'd7),          32'h0, 32'h0, 4'h0, 1'b1, 3'd2, 32'd7,        1'b0, 8'h00, 1'b0};
    tbl[5]  = '{f_alu(4'hB, 3'd4, 3'd1, 3'd2), 32'd7, 32'd7, 4'hB, 1'b1, 3'd4, 32'd0, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{f_brz(8'h3C),               32'h0, 32'h0, 4'h0, 1'b0, 3'd0, 32'd0,        1'b1, 8'h3C, 1'b0};
    tbl[7]  = '{f_alu(4'hA, 3'd5, 3'd1, 3'd2), 32'd7, 32'd7, 4'hA, 1'b1, 3'd5, 32'd14, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{f_brz(8'h3C),               32'h0, 32'h0, 4'h0, 1'b0, 3'd0, 32'd0,        1'b0, 8'h00, 1'b0};
    tbl[9]  = '{f_ldi(3'd1, 9'd16),         32'h0, 32'h0, 4'h0, 1'b1, 3'd1, 32'd16,       1'b0, 8'h00, 1'b0};
    tbl[10] = '{f_alu(4'hC, 3'd1, 3'd1, 3'd1), 32'd16, 32'd16, 4'hC, 1'b1, 3'd1, 32'd256, 1'b0, 8'h00, 1'b0};
    tbl[11] = '{f_alu(4'hC, 3'd1, 3'd1, 3'd1), 32'd256, 32'd256, 4'hC, 1'b1, 3'd1, 32'h10000, 1'b0, 8'h00, 1'b0};
    tbl[12] = '{f_alu(4'hC, 3'd6, 3'd1, 3'd1), 32'h10000, 32'h10000, 4'hC, 1'b1, 3'd6, 32'd0, 1'b0, 8'h00, 1'b0};
    tbl[13] = '{f_brz(8'hA5),               32'h0, 32'h0, 4'h0, 1'b0, 3'd0, 32'd0,        1'b1, 8'hA5, 1'b0};
    tbl[14] = '{f_ldi(3'd1, 9'd4),          32'h0, 32'h0, 4'h0, 1'b1, 3'd1, 32'd4,        1'b0, 8'h00, 1'b0};
    tbl[15] = '{f_alu(4'hA, 3'd0, 3'd1, 3'd1), 32'd4, 32'd4, 4'hA, 1'b1, 3'd0, 32'd8, 1'b0, 8'h00, 1'b0};
    tbl[16] = '{f_alu(4'hA, 3'd7, 3'd0, 3'd0), 32'd0, 32'd0, 4'hA, 1'b1, 3'd7, 32'd0, 1'b0, 8'h00, 1'b0};
    tbl[17] = '{16'hFE48,                   32'h0, 32'h0, 4'h0, 1'b0, 3'd0, 32'd0,        1'b0, 8'h00, 1'b1};
    tbl[18] = '{f_alu(4'hA, 3'd5, 3'd7, 3'd1), 32'd0, 32'd4, 4'hA, 1'b1, 3'd5, 32'd4, 1'b0, 8'h00, 1'b0};
    tbl[19] = '{16'h0000,                   32'h0, 32'h0, 4'h0, 1'b0, 3'd0, 32'd0,        1'b0, 8'h00, 1'b0};
    tbl[20] = '{16'h3000,                   32'h0, 32'h0, 4'h0, 1'b0, 3'd0, 32'd0,        1'b0, 8'h00, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", {31'b0, in_ready}, 32'd1);
    chk("rst pulses", {29'b0, res_valid, br_taken, illegal}, 32'd0);
    chk("rst buses", A_bus | B_bus | {28'b0, op}, 32'd0);
    chk("rst res", {21'b0, br_target, res_rd} | res_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while LDI R1,5 is in EXEC: the write must be dropped
    in_valid = 1'b1;
    in_instr = f_ldi(3'd1, 9'd5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst ready", {31'b0, in_ready}, 32'd1);
    chk("midrst res_valid", {31'b0, res_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("midrst no_result", {31'b0, res_valid}, 32'd0);
    end
    v = '{f_alu(4'hA, 3'd2, 3'd1, 3'd1), 32'd0, 32'd0, 4'hA, 1'b1, 3'd2, 32'd0, 1'b0, 8'h00, 1'b0};
    apply(v, 99);

    for (int i = 0; i < 21; i++) apply(tbl[i], i);

    // Back-to-back with in_valid held high for six instructions
    for (int i = 0; i < 6; i++) b2b_instr[i] = f_ldi(3'(i + 1), 9'(i + 10));
    k = 0;
    nres = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (res_valid) begin
        if (nres < 6) begin
          chk($sformatf("b2b rd%0d", nres), {29'b0, res_rd}, 32'(nres + 1));
          chk($sformatf("b2b data%0d", nres), res_data, 32'(nres + 10));
        end
        nres++;
      end
      if (in_ready) begin
        if (k < 6) begin
          in_valid = 1'b1;
          in_instr = b2b_instr[k];
          acc_cyc[k] = cyc;
          k++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    chk("b2b accepts", 32'(k), 32'd6);
    chk("b2b results", 32'(nres), 32'd6);
    for (int i = 1; i < 6; i++)
      chk($sformatf("b2b spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);

    // Idle with in_valid low: buses stay quiet, garbage on in_instr ignored
    in_valid = 1'b0;
    in_instr = 16'hA248;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("idle%0d", c), A_bus | B_bus | {28'b0, op} | {31'b0, ~in_ready}, 32'd0);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
